// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input front-end: PS/2 scancodes, joystick bit
// positions and the cabinet rotation remap helper.
package arcade_input_pkg;

    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_BTN0  = 4;

    localparam int MAX_BUTTONS = 6;

    // Index of each direction inside a 4-bit {up,down,left,right} vector
    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_UP    = 2'd3
    } dir_idx_e;

    localparam logic [7:0] SC_P1_UP    = 8'h75;
    localparam logic [7:0] SC_P1_DOWN  = 8'h72;
    localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT = 8'h74;
    localparam logic [7:0] SC_START1_A = 8'h05;
    localparam logic [7:0] SC_START1_B = 8'h16;
    localparam logic [7:0] SC_COIN1    = 8'h2E;
    localparam logic [7:0] SC_TEST     = 8'h2C;

    localparam logic [7:0] SC_P2_UP    = 8'h2D;
    localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
    localparam logic [7:0] SC_P2_LEFT  = 8'h23;
    localparam logic [7:0] SC_P2_RIGHT = 8'h34;
    localparam logic [7:0] SC_START2_A = 8'h06;
    localparam logic [7:0] SC_START2_B = 8'h1E;
    localparam logic [7:0] SC_COIN2    = 8'h36;

    // Button k of a player lives at byte k (button 0 in the low byte)
    localparam logic [8*MAX_BUTTONS-1:0] P1_BTN_CODES =
        {8'h22, 8'h1A, 8'h12, 8'h11, 8'h29, 8'h14};
    localparam logic [8*MAX_BUTTONS-1:0] P2_BTN_CODES =
        {8'h21, 8'h2A, 8'h24, 8'h15, 8'h1B, 8'h1C};

    function automatic logic [3:0] rot_remap(input logic [3:0] dir4,
                                             input logic       rotEn,
                                             input logic       ccw);
        logic [3:0] res;
        res = dir4;
        if (rotEn && !ccw) begin
            res[DIR_UP]    = dir4[DIR_LEFT];
            res[DIR_DOWN]  = dir4[DIR_RIGHT];
            res[DIR_LEFT]  = dir4[DIR_DOWN];
            res[DIR_RIGHT] = dir4[DIR_UP];
        end else if (rotEn && ccw) begin
            res[DIR_UP]    = dir4[DIR_RIGHT];
            res[DIR_DOWN]  = dir4[DIR_LEFT];
            res[DIR_LEFT]  = dir4[DIR_UP];
            res[DIR_RIGHT] = dir4[DIR_DOWN];
        end
        return res;
    endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_pulse.sv
// Turns a raw coin level into one fixed-width pulse per press; edges that arrive
// while a pulse is still running are dropped rather than extending it.
module coin_pulse #(
    parameter int COIN_PULSE = 600000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic coin_raw_i,
    output logic coin_o
);

    localparam int CW = (COIN_PULSE > 1) ? $clog2(COIN_PULSE + 1) : 1;

    logic [CW-1:0] count_q, count_d;
    logic          prev_q;

    always_comb begin
        count_d = count_q;
        if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end else if (coin_raw_i && !prev_q) begin
            count_d = CW'(COIN_PULSE);
        end
    end

    // History clears in reset so a coin held through reset still pays out once
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            count_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            prev_q  <= coin_raw_i;
        end
    end

    assign coin_o = (count_q != '0);

endmodule

// File: rtl/arcade_input_mapper.sv
// Arcade input front-end: decodes PS/2 make/break events into held keys, merges them
// with the HPS joysticks, then applies rotation, autofire and coin pulse shaping.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_BUTTONS  = 3,
    parameter int COIN_PULSE   = 600000,
    parameter int AUTOFIRE_DIV = 720000
) (
    input  logic                               clk_sys,
    input  logic                               reset,
    input  logic [10:0]                        ps2_key,
    input  logic [15:0]                        joystick_0,
    input  logic [15:0]                        joystick_1,
    input  logic                               joy_share,
    input  logic                               rotate,
    input  logic                               rot_ccw,
    input  logic [NUM_BUTTONS-1:0]             autofire_en,
    output logic [4*NUM_PLAYERS-1:0]           dir_out,
    output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btn_out,
    output logic [NUM_PLAYERS-1:0]             start_out,
    output logic [1:0]                         coin_out,
    output logic                               test_out
);

    localparam int START_BIT = JOY_BTN0 + NUM_BUTTONS;
    localparam int COIN_BIT  = START_BIT + 1;
    localparam int KW        = COIN_BIT + 1;
    localparam int AFW       = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;

    logic            oldTgl_q;
    logic [KW-1:0]   keyP1_q, keyP1_d;
    logic [KW-1:0]   keyP2_q, keyP2_d;
    logic            testKey_q, testKey_d;

    logic            keyEvent;
    logic            keyPressed;
    logic            keyExt;
    logic [7:0]      keyCode;

    logic [KW-1:0]   joyP1, joyP2;
    logic [KW-1:0]   raw [2];
    logic [1:0]      coinRaw;

    logic [AFW-1:0]  afCount_q, afCount_d;
    logic            phase_q, phase_d;

    logic [4*NUM_PLAYERS-1:0]           dirOut_q, dirOut_d;
    logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btnOut_q, btnOut_d;
    logic [NUM_PLAYERS-1:0]             startOut_q, startOut_d;
    logic                               testOut_q;

    logic            unusedJoyBits;

    assign keyEvent   = (ps2_key[10] != oldTgl_q);
    assign keyPressed = ps2_key[9];
    assign keyExt     = ps2_key[8];
    assign keyCode    = ps2_key[7:0];

    // Key state is kept in joystick bit layout so merging is a plain OR
    always_comb begin
        keyP1_d   = keyP1_q;
        keyP2_d   = keyP2_q;
        testKey_d = testKey_q;
        if (keyEvent) begin
            if (keyExt) begin
                case (keyCode)
                    SC_P1_UP:    keyP1_d[JOY_UP]    = keyPressed;
                    SC_P1_DOWN:  keyP1_d[JOY_DOWN]  = keyPressed;
                    SC_P1_LEFT:  keyP1_d[JOY_LEFT]  = keyPressed;
                    SC_P1_RIGHT: keyP1_d[JOY_RIGHT] = keyPressed;
                    default: ;
                endcase
            end else begin
                case (keyCode)
                    SC_START1_A, SC_START1_B: keyP1_d[START_BIT] = keyPressed;
                    SC_COIN1:                 keyP1_d[COIN_BIT]  = keyPressed;
                    SC_TEST:                  testKey_d          = keyPressed;
                    SC_P2_UP:                 keyP2_d[JOY_UP]    = keyPressed;
                    SC_P2_DOWN:               keyP2_d[JOY_DOWN]  = keyPressed;
                    SC_P2_LEFT:               keyP2_d[JOY_LEFT]  = keyPressed;
                    SC_P2_RIGHT:              keyP2_d[JOY_RIGHT] = keyPressed;
                    SC_START2_A, SC_START2_B: keyP2_d[START_BIT] = keyPressed;
                    SC_COIN2:                 keyP2_d[COIN_BIT]  = keyPressed;
                    default: ;
                endcase
                for (int k = 0; k < NUM_BUTTONS; k++) begin
                    if (keyCode == P1_BTN_CODES[8*k +: 8]) begin
                        keyP1_d[JOY_BTN0 + k] = keyPressed;
                    end
                    if (keyCode == P2_BTN_CODES[8*k +: 8]) begin
                        keyP2_d[JOY_BTN0 + k] = keyPressed;
                    end
                end
            end
        end
    end

    assign joyP1 = joy_share ? (joystick_0[KW-1:0] | joystick_1[KW-1:0]) : joystick_0[KW-1:0];
    assign joyP2 = joy_share ? (joystick_0[KW-1:0] | joystick_1[KW-1:0]) : joystick_1[KW-1:0];

    assign raw[0] = keyP1_q | joyP1;
    assign raw[1] = keyP2_q | joyP2;

    assign unusedJoyBits = &{1'b0, joystick_0[15:KW], joystick_1[15:KW]};

    // A single-player build drops the P2 coin key but still honours the joystick coin
    assign coinRaw[0] = raw[0][COIN_BIT];
    assign coinRaw[1] = (NUM_PLAYERS > 1) ? raw[1][COIN_BIT] : joyP2[COIN_BIT];

    always_comb begin
        afCount_d = afCount_q + AFW'(1);
        phase_d   = phase_q;
        if (afCount_q == AFW'(AUTOFIRE_DIV - 1)) begin
            afCount_d = '0;
            phase_d   = ~phase_q;
        end
    end

    always_comb begin
        dirOut_d   = '0;
        btnOut_d   = '0;
        startOut_d = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            dirOut_d[4*p +: 4] = rot_remap(raw[p][3:0], rotate, rot_ccw);
            for (int k = 0; k < NUM_BUTTONS; k++) begin
                btnOut_d[NUM_BUTTONS*p + k] =
                    raw[p][JOY_BTN0 + k] & (autofire_en[k] ? phase_q : 1'b1);
            end
            startOut_d[p] = raw[p][START_BIT];
        end
    end

    // Reset resyncs the toggle history so a toggle pending across reset is not an event
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            oldTgl_q   <= ps2_key[10];
            keyP1_q    <= '0;
            keyP2_q    <= '0;
            testKey_q  <= 1'b0;
            afCount_q  <= '0;
            phase_q    <= 1'b1;
            dirOut_q   <= '0;
            btnOut_q   <= '0;
            startOut_q <= '0;
            testOut_q  <= 1'b0;
        end else begin
            oldTgl_q   <= ps2_key[10];
            keyP1_q    <= keyP1_d;
            keyP2_q    <= keyP2_d;
            testKey_q  <= testKey_d;
            afCount_q  <= afCount_d;
            phase_q    <= phase_d;
            dirOut_q   <= dirOut_d;
            btnOut_q   <= btnOut_d;
            startOut_q <= startOut_d;
            testOut_q  <= testKey_q;
        end
    end

    for (genvar c = 0; c < 2; c++) begin : gCoin
        coin_pulse #(
            .COIN_PULSE(COIN_PULSE)
        ) uCoin (
            .clk_sys   (clk_sys),
            .reset     (reset),
            .coin_raw_i(coinRaw[c]),
            .coin_o    (coin_out[c])
        );
    end

    assign dir_out   = dirOut_q;
    assign btn_out   = btnOut_q;
    assign start_out = startOut_q;
    assign test_out  = testOut_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper: directed scenarios followed by random
// traffic, all compared against a keymap/timing reference model.
module tb_arcade_input_mapper;

    localparam int NP = 2;
    localparam int NB = 3;
    localparam int CP = 10;
    localparam int AF = 4;

    logic                clk_sys     = 1'b0;
    logic                reset       = 1'b1;
    logic [10:0]         ps2_key     = '0;
    logic [15:0]         joystick_0  = '0;
    logic [15:0]         joystick_1  = '0;
    logic                joy_share   = 1'b0;
    logic                rotate      = 1'b0;
    logic                rot_ccw     = 1'b0;
    logic [NB-1:0]       autofire_en = '0;
    logic [4*NP-1:0]     dir_out;
    logic [NB*NP-1:0]    btn_out;
    logic [NP-1:0]       start_out;
    logic [1:0]          coin_out;
    logic                test_out;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .NUM_PLAYERS (NP),
        .NUM_BUTTONS (NB),
        .COIN_PULSE  (CP),
        .AUTOFIRE_DIV(AF)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .joy_share  (joy_share),
        .rotate     (rotate),
        .rot_ccw    (rot_ccw),
        .autofire_en(autofire_en),
        .dir_out    (dir_out),
        .btn_out    (btn_out),
        .start_out  (start_out),
        .coin_out   (coin_out),
        .test_out   (test_out)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] p1Btn [6] = '{8'h14, 8'h29, 8'h11, 8'h12, 8'h1A, 8'h22};
    logic [7:0] p2Btn [6] = '{8'h1C, 8'h1B, 8'h15, 8'h24, 8'h2A, 8'h21};
    logic [7:0] pool  [24] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h29, 8'h11, 8'h12,
                               8'h1A, 8'h22, 8'h05, 8'h16, 8'h2E, 8'h2C, 8'h2D, 8'h2B,
                               8'h23, 8'h34, 8'h1C, 8'h1B, 8'h15, 8'h06, 8'h1E, 8'h36};

    // Held controls: player p control in joystick layout at 16*p+bit, test key at 40
    bit  mCtl [48];
    bit  mOldTgl;
    int  afN;
    int  edgeN;
    int  coinStart [2];
    bit  coinPrev [2];

    logic [4*NP-1:0]  expDir;
    logic [NB*NP-1:0] expBtn;
    logic [NP-1:0]    expStart;
    logic [1:0]       expCoin;
    logic             expTest;

    function automatic int ctlOf(input bit ext, input logic [7:0] code);
        if (ext) begin
            case (code)
                8'h75:   return 3;
                8'h72:   return 2;
                8'h6B:   return 1;
                8'h74:   return 0;
                default: return -1;
            endcase
        end
        for (int k = 0; k < NB; k++) begin
            if (code == p1Btn[k]) return 4 + k;
            if (code == p2Btn[k]) return 20 + k;
        end
        case (code)
            8'h05, 8'h16: return 4 + NB;
            8'h2E:        return 5 + NB;
            8'h2C:        return 40;
            8'h2D:        return 19;
            8'h2B:        return 18;
            8'h23:        return 17;
            8'h34:        return 16;
            8'h06, 8'h1E: return 20 + NB;
            8'h36:        return 21 + NB;
            default:      return -1;
        endcase
    endfunction

    task automatic sendKey(input bit ext, input logic [7:0] code, input bit pressed);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (dir_out === expDir) else begin
            failures++;
            $error("FAIL %s dir_out got=%h exp=%h", tag, dir_out, expDir);
        end
        checks++;
        assert (btn_out === expBtn) else begin
            failures++;
            $error("FAIL %s btn_out got=%h exp=%h", tag, btn_out, expBtn);
        end
        checks++;
        assert (start_out === expStart) else begin
            failures++;
            $error("FAIL %s start_out got=%h exp=%h", tag, start_out, expStart);
        end
        checks++;
        assert (coin_out === expCoin) else begin
            failures++;
            $error("FAIL %s coin_out got=%h exp=%h", tag, coin_out, expCoin);
        end
        checks++;
        assert (test_out === expTest) else begin
            failures++;
            $error("FAIL %s test_out got=%h exp=%h", tag, test_out, expTest);
        end
    endtask

    task automatic checkBits(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    // Predict the outputs of the coming edge from the inputs seen at it, then clock and compare
    task automatic applyStimulus(input string tag);
        logic [15:0] j;
        bit u, d, l, r, oU, oD, oL, oR, phase, b, wasHigh;
        bit cRaw [2];
        int id;
        if (reset) begin
            foreach (mCtl[i]) mCtl[i] = 1'b0;
            mOldTgl = ps2_key[10];
            afN = 0;
            for (int c = 0; c < 2; c++) begin
                coinPrev[c]  = 1'b0;
                coinStart[c] = -1000;
            end
            expDir = '0; expBtn = '0; expStart = '0; expCoin = '0; expTest = 1'b0;
        end else begin
            phase = ((afN / AF) % 2) == 0;
            for (int p = 0; p < NP; p++) begin
                j = joy_share ? (joystick_0 | joystick_1) : ((p == 0) ? joystick_0 : joystick_1);
                u = mCtl[16*p + 3] | j[3];
                d = mCtl[16*p + 2] | j[2];
                l = mCtl[16*p + 1] | j[1];
                r = mCtl[16*p + 0] | j[0];
                if (!rotate) begin
                    oU = u; oD = d; oL = l; oR = r;
                end else if (!rot_ccw) begin
                    oU = l; oD = r; oL = d; oR = u;
                end else begin
                    oU = r; oD = l; oL = u; oR = d;
                end
                expDir[4*p +: 4] = {oU, oD, oL, oR};
                for (int k = 0; k < NB; k++) begin
                    b = mCtl[16*p + 4 + k] | j[4 + k];
                    expBtn[NB*p + k] = b & (autofire_en[k] ? phase : 1'b1);
                end
                expStart[p] = mCtl[16*p + 4 + NB] | j[4 + NB];
                cRaw[p]     = mCtl[16*p + 5 + NB] | j[5 + NB];
            end
            expTest = mCtl[40];
            for (int c = 0; c < 2; c++) begin
                wasHigh = (edgeN - 1 >= coinStart[c]) && (edgeN - 1 < coinStart[c] + CP);
                if (cRaw[c] && !coinPrev[c] && !wasHigh) coinStart[c] = edgeN;
                coinPrev[c] = cRaw[c];
                expCoin[c]  = (edgeN >= coinStart[c]) && (edgeN < coinStart[c] + CP);
            end
            afN++;
            if (ps2_key[10] != mOldTgl) begin
                id = ctlOf(ps2_key[8], ps2_key[7:0]);
                if (id >= 0) mCtl[id] = ps2_key[9];
            end
            mOldTgl = ps2_key[10];
        end
        edgeN++;
        @(posedge clk_sys);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        int hi;
        int pick;
        logic [7:0] code;
        bit ext;

        edgeN = 0;
        $display("[TB] start");

        reset = 1'b1;
        repeat (3) applyStimulus("reset");
        reset = 1'b0;
        applyStimulus("idle");

        sendKey(1'b1, 8'h75, 1'b1);
        applyStimulus("up_press_e1");
        checkBits("up_press_edge1", 32'(dir_out[3]), 32'd0);
        applyStimulus("up_press_e2");
        checkBits("up_press_edge2", 32'(dir_out[3]), 32'd1);
        sendKey(1'b1, 8'h75, 1'b0);
        applyStimulus("up_release_e1");
        checkBits("up_release_edge1", 32'(dir_out[3]), 32'd1);
        applyStimulus("up_release_e2");
        checkBits("up_release_edge2", 32'(dir_out[3]), 32'd0);
        sendKey(1'b0, 8'h75, 1'b1);
        repeat (3) applyStimulus("up_noext");
        checkBits("up_noext", 32'(dir_out), 32'd0);

        joystick_0 = 16'h0001;
        rotate = 1'b1; rot_ccw = 1'b0;
        applyStimulus("rot_cw");
        checkBits("rot_cw", 32'(dir_out[3:0]), 32'b0100);
        rot_ccw = 1'b1;
        applyStimulus("rot_ccw");
        checkBits("rot_ccw", 32'(dir_out[3:0]), 32'b1000);
        rotate = 1'b0;
        applyStimulus("rot_off");
        checkBits("rot_off", 32'(dir_out[3:0]), 32'b0001);
        joystick_0 = '0;
        applyStimulus("rot_clear");

        joystick_1 = 16'h0010;
        joy_share = 1'b0;
        applyStimulus("share_off");
        checkBits("share_off", 32'(btn_out), 32'b001000);
        joy_share = 1'b1;
        applyStimulus("share_on");
        checkBits("share_on", 32'(btn_out), 32'b001001);
        joystick_1 = '0; joy_share = 1'b0;
        applyStimulus("share_clear");

        sendKey(1'b0, 8'h2E, 1'b1);
        hi = 0;
        for (int i = 0; i < 3 * CP; i++) begin
            if (i == 3) sendKey(1'b0, 8'h2E, 1'b0);
            if (i == 5) sendKey(1'b0, 8'h2E, 1'b1);
            applyStimulus("coin_hold");
            hi += int'(coin_out[0]);
        end
        checkBits("coin_width", 32'(hi), 32'(CP));
        sendKey(1'b0, 8'h2E, 1'b0);
        repeat (2) applyStimulus("coin_release");

        autofire_en = 3'b011;
        sendKey(1'b0, 8'h14, 1'b1);
        applyStimulus("af_key0");
        sendKey(1'b0, 8'h29, 1'b1);
        repeat (20) applyStimulus("autofire");
        autofire_en = '0;
        repeat (6) applyStimulus("af_off");
        checkBits("af_off_steady", 32'(btn_out[1:0]), 32'b11);
        sendKey(1'b0, 8'h14, 1'b0);
        applyStimulus("af_rel0");
        sendKey(1'b0, 8'h29, 1'b0);
        repeat (2) applyStimulus("af_rel1");

        joystick_0 = 16'h0100;
        repeat (3) applyStimulus("coin_joy");
        sendKey(1'b0, 8'h2C, 1'b1);
        reset = 1'b1;
        applyStimulus("reset_mid");
        checkBits("reset_all_zero", 32'({dir_out, btn_out, start_out, coin_out, test_out}), 32'd0);
        reset = 1'b0;
        repeat (4) applyStimulus("post_reset");
        checkBits("no_spurious_event", 32'(test_out), 32'd0);
        repeat (4) applyStimulus("post_reset_coin");
        joystick_0 = '0;
        repeat (12) applyStimulus("post_reset_drain");

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                pick = $urandom_range(0, 25);
                code = (pick < 24) ? pool[pick] : 8'($urandom);
                ext  = (pick < 4) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
                sendKey(ext, code, 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 7) == 0) begin
                joystick_0 = (16'($urandom) & 16'hFEFF) | (($urandom_range(0, 15) == 0) ? 16'h0100 : 16'h0000);
                joystick_1 = (16'($urandom) & 16'hFEFF) | (($urandom_range(0, 15) == 0) ? 16'h0100 : 16'h0000);
            end
            if ($urandom_range(0, 15) == 0) {joy_share, rotate, rot_ccw} = 3'($urandom);
            if ($urandom_range(0, 15) == 0) autofire_en = 3'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            applyStimulus("random");
        end
        reset = 1'b0;
        applyStimulus("final");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
